sprite_rom_arbiter: RTL and testbench



---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_rom_arbiter_if.sv | 28 ++
 rtl/rr_pick.sv | 30 +++
 rtl/sprite_rom_arbiter.sv | 68 ++++++
 tb/tb_sprite_rom_arbiter.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite ROM path: widths, requester indices
// and the RGB field layout of a 12-bit sprite word.
package sprite_pkg;

  localparam int SPRITE_NUM_REQ = 3;
  localparam int SPRITE_ADDR_W  = 12;
  localparam int SPRITE_DATA_W  = 12;

  localparam int REQ_FOOD    = 0;
  localparam int REQ_LINEAR1 = 1;
  localparam int REQ_LINEAR2 = 2;

  localparam int R_MSB = 11;
  localparam int G_MSB = 7;
  localparam int B_MSB = 3;

  typedef logic [SPRITE_DATA_W-1:0] rgb_word_t;

  function automatic logic [3:0] red_of(input rgb_word_t w);
    return w[R_MSB -: 4];
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Request/grant, ROM and data-return signals between the sprite
// requesters, the shared ROM and the arbiter.
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 12
);
  logic                      enable;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic                      busy;

  // Requesters plus the ROM model drive the arbiter's inputs.
  modport master (
    output enable, req, req_addr, rom_data,
    input  gnt, rom_addr, rd_valid, rd_data, busy
  );

  modport slave (
    input  enable, req, req_addr, rom_data,
    output gnt, rom_addr, rd_valid, rd_data, busy
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of eff_req searching
// upward from last+1, wrapping modulo N.
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     eff_req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             valid
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    idx        = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(last) + k) % N);
      if (!valid && eff_req[idx]) begin
        valid       = 1'b1;
        winner[idx] = 1'b1;
        winner_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin sharing of one asynchronous-read sprite ROM between the
// pixel-layer requesters, with registered address and data-return stages.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = SPRITE_NUM_REQ,
  parameter int ADDR_W  = SPRITE_ADDR_W,
  parameter int DATA_W  = SPRITE_DATA_W
) (
  input logic                clk,
  input logic                rst_n,
  sprite_rom_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] gnt_reg, rd_valid_reg, eff_req, pick_onehot;
  logic [IDX_W-1:0]   last_reg, pick_idx;
  logic               pick_valid, grant;
  logic [ADDR_W-1:0]  rom_addr_reg;
  logic [DATA_W-1:0]  rd_data_reg;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // A request whose grant is visible right now is already being served.
  assign eff_req = bus.req & ~gnt_reg;
  assign grant   = bus.enable & pick_valid;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .eff_req    (eff_req),
    .last       (last_reg),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_reg      <= '0;
      rom_addr_reg <= '0;
      last_reg     <= IDX_W'(NUM_REQ - 1);
      rd_valid_reg <= '0;
      rd_data_reg  <= '0;
    end else begin
      gnt_reg      <= grant ? pick_onehot : '0;
      rd_valid_reg <= gnt_reg;
      if (grant) begin
        rom_addr_reg <= addr_arr[pick_idx];
        last_reg     <= pick_idx;
      end
      if (|gnt_reg) begin
        rd_data_reg <= bus.rom_data;
      end
    end
  end

  assign bus.gnt      = gnt_reg;
  assign bus.rom_addr = rom_addr_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.rd_data  = rd_data_reg;
  assign bus.busy     = (|gnt_reg) | (|rd_valid_reg);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed vector table for the sprite ROM arbiter followed by a randomized
// requester run checked for latency, fairness bound and returned data.
module tb_sprite_rom_arbiter;
  import sprite_pkg::*;

  localparam int N  = 3;
  localparam int AW = 12;
  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst_n;
  logic [DW-1:0] rom_xor = '0;

  always #5 clk = ~clk;

  sprite_rom_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  // ROM model: asynchronous read, word derived from the address.
  assign bus.rom_data = bus.rom_addr ^ rom_xor;

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic          rst_n;
    logic          en;
    logic [2:0]    req;
    logic [AW-1:0] a0, a1, a2;
    logic [2:0]    gnt;
    logic [2:0]    rv;
    logic [DW-1:0] rd;
    logic [AW-1:0] ra;
    logic          busy;
  } vec_t;

  vec_t vecs [28];

  // Random-phase requester state
  logic          pend  [N];
  logic [AW-1:0] raddr [N];
  int            miss  [N];
  logic [2:0]    exp_rv;
  logic [DW-1:0] exp_rd;

  initial begin
    // Round-robin over all three, then reset while gnt=100 is visible
    vecs[0]  = '{1'b0, 1'b1, 3'b111, 12'h010, 12'h020, 12'h030, 3'b000, 3'b000, 12'h000, 12'h000, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 3'b111, 12'h010, 12'h020, 12'h030, 3'b001, 3'b000, 12'h000, 12'h010, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 3'b111, 12'h010, 12'h020, 12'h030, 3'b010, 3'b001, 12'h010, 12'h020, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 3'b111, 12'h010, 12'h020, 12'h030, 3'b100, 3'b010, 12'h020, 12'h030, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 3'b111, 12'h010, 12'h020, 12'h030, 3'b001, 3'b100, 12'h030, 12'h010, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 3'b111, 12'h010, 12'h020, 12'h030, 3'b010, 3'b001, 12'h010, 12'h020, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 3'b111, 12'h010, 12'h020, 12'h030, 3'b100, 3'b010, 12'h020, 12'h030, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 3'b111, 12'h010, 12'h020, 12'h030, 3'b000, 3'b000, 12'h000, 12'h000, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 3'b111, 12'h010, 12'h020, 12'h030, 3'b001, 3'b000, 12'h000, 12'h010, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 3'b000, 12'h010, 12'h020, 12'h030, 3'b000, 3'b001, 12'h010, 12'h010, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 3'b000, 12'h010, 12'h020, 12'h030, 3'b000, 3'b000, 12'h010, 12'h010, 1'b0};
    // Single requester 1 holding its request: grants on alternate cycles
    vecs[11] = '{1'b1, 1'b1, 3'b010, 12'h010, 12'h2A5, 12'h030, 3'b010, 3'b000, 12'h010, 12'h2A5, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 3'b010, 12'h010, 12'h2A5, 12'h030, 3'b000, 3'b010, 12'h2A5, 12'h2A5, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 3'b010, 12'h010, 12'h2A5, 12'h030, 3'b010, 3'b000, 12'h2A5, 12'h2A5, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 3'b010, 12'h010, 12'h2A5, 12'h030, 3'b000, 3'b010, 12'h2A5, 12'h2A5, 1'b1};
    vecs[15] = '{1'b1, 1'b1, 3'b010, 12'h010, 12'h2A5, 12'h030, 3'b010, 3'b000, 12'h2A5, 12'h2A5, 1'b1};
    vecs[16] = '{1'b1, 1'b1, 3'b010, 12'h010, 12'h2A5, 12'h030, 3'b000, 3'b010, 12'h2A5, 12'h2A5, 1'b1};
    vecs[17] = '{1'b1, 1'b1, 3'b000, 12'h010, 12'h2A5, 12'h030, 3'b000, 3'b000, 12'h2A5, 12'h2A5, 1'b0};
    // enable dropped the cycle after gnt=010; the return still arrives
    vecs[18] = '{1'b1, 1'b1, 3'b010, 12'h010, 12'h020, 12'h030, 3'b010, 3'b000, 12'h2A5, 12'h020, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 3'b111, 12'h010, 12'h020, 12'h030, 3'b000, 3'b010, 12'h020, 12'h020, 1'b1};
    vecs[20] = '{1'b1, 1'b0, 3'b111, 12'h010, 12'h020, 12'h030, 3'b000, 3'b000, 12'h020, 12'h020, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 3'b000, 12'h010, 12'h020, 12'h030, 3'b000, 3'b000, 12'h020, 12'h020, 1'b0};
    // Requesters 0 and 2 alternate; 1 idle
    vecs[22] = '{1'b1, 1'b1, 3'b101, 12'h111, 12'h222, 12'h333, 3'b100, 3'b000, 12'h020, 12'h333, 1'b1};
    vecs[23] = '{1'b1, 1'b1, 3'b101, 12'h111, 12'h222, 12'h333, 3'b001, 3'b100, 12'h333, 12'h111, 1'b1};
    vecs[24] = '{1'b1, 1'b1, 3'b101, 12'h111, 12'h222, 12'h333, 3'b100, 3'b001, 12'h111, 12'h333, 1'b1};
    vecs[25] = '{1'b1, 1'b1, 3'b101, 12'h111, 12'h222, 12'h333, 3'b001, 3'b100, 12'h333, 12'h111, 1'b1};
    vecs[26] = '{1'b1, 1'b1, 3'b000, 12'h111, 12'h222, 12'h333, 3'b000, 3'b001, 12'h111, 12'h111, 1'b1};
    vecs[27] = '{1'b1, 1'b1, 3'b000, 12'h111, 12'h222, 12'h333, 3'b000, 3'b000, 12'h111, 12'h111, 1'b0};

    for (int v = 0; v < 28; v++) begin
      rst_n        = vecs[v].rst_n;
      bus.enable   = vecs[v].en;
      bus.req      = vecs[v].req;
      bus.req_addr = {vecs[v].a2, vecs[v].a1, vecs[v].a0};
      @(posedge clk);
      #1;
      $display("[TB] vec %0d: gnt=%b rd_valid=%b rd_data=%h rom_addr=%h busy=%b",
               v, bus.gnt, bus.rd_valid, bus.rd_data, bus.rom_addr, bus.busy);
      check($sformatf("vec%0d_gnt", v),      32'(bus.gnt),      32'(vecs[v].gnt));
      check($sformatf("vec%0d_rd_valid", v), 32'(bus.rd_valid), 32'(vecs[v].rv));
      check($sformatf("vec%0d_rd_data", v),  32'(bus.rd_data),  32'(vecs[v].rd));
      check($sformatf("vec%0d_rom_addr", v), 32'(bus.rom_addr), 32'(vecs[v].ra));
      check($sformatf("vec%0d_busy", v),     32'(bus.busy),     32'(vecs[v].busy));
    end

    // Randomized requesters following the hold-until-grant protocol
    rom_xor    = 12'h5A5;
    bus.enable = 1'b1;
    exp_rv     = '0;
    exp_rd     = '0;
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      raddr[i] = '0;
      miss[i]  = 0;
    end
    bus.req      = '0;
    bus.req_addr = '0;

    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      check("rnd_rd_valid", 32'(bus.rd_valid), 32'(exp_rv));
      if (exp_rv != 3'b000) begin
        check("rnd_rd_data", 32'(bus.rd_data), 32'(exp_rd));
      end
      check("rnd_gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
      for (int i = 0; i < N; i++) begin
        if (bus.gnt[i]) begin
          check("rnd_gnt_eligible", 32'(pend[i] && (miss[i] >= 0)), 32'd1);
          check("rnd_rom_addr", 32'(bus.rom_addr), 32'(raddr[i]));
          exp_rd = raddr[i] ^ rom_xor;
          if ($urandom_range(1) == 1) begin
            pend[i]  = 1'b1;
            raddr[i] = AW'($urandom_range(4095));
            miss[i]  = -1;
          end else begin
            pend[i] = 1'b0;
          end
        end else if (pend[i]) begin
          miss[i]++;
          check("rnd_starvation", 32'(miss[i] <= N - 1), 32'd1);
        end else if ($urandom_range(1) == 1) begin
          pend[i]  = 1'b1;
          raddr[i] = AW'($urandom_range(4095));
          miss[i]  = 0;
        end
      end
      exp_rv = bus.gnt;
      for (int i = 0; i < N; i++) begin
        bus.req[i]                 = pend[i];
        bus.req_addr[i*AW +: AW]   = raddr[i];
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
